gps_ack_peak: RTL and testbench

GPS_ACK_PEAK -- requirements
Module: gps_ack_peak

---
 rtl/gps_ack_peak.sv | 183 ++++++++++++++++++
 tb/tb_gps_ack_peak.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/gps_ack_peak.sv
// rtl/gps_ack_peak.sv - GPS acquisition peak/second-peak tracker and detection decision
// Optional feature: define GPS_ACK_PEAK_SUM_EN to add the sum_val accumulator output.

module gps_ack_peak #(
   parameter int N_PHASES    = 1023,
   parameter int RATIO_SHIFT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [4:0]  sat_in,
   input  logic        corr_complete,
   input  logic [9:0]  code_phase,
   input  logic [11:0] integrator,
   output logic        busy,
   output logic        done,
   output logic        detected,
   output logic [9:0]  peak_phase,
   output logic [11:0] peak_val,
   output logic [11:0] second_val,
`ifdef GPS_ACK_PEAK_SUM_EN
   output logic [21:0] sum_val,
`endif
   output logic [4:0]  acq_sat
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DECIDE  = 2'd2
   } state_t;

   // Phase count and last legal phase, 11 bits so code_phase = 1023 compares cleanly
   localparam logic [10:0] N_CNT = 11'(N_PHASES);
   localparam logic [10:0] N_MAX = 11'(N_PHASES - 1);

   state_t      state_q, state_d;
   logic [10:0] count_q, count_d;
   logic        prev_q, prev_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        detected_q, detected_d;
   logic [9:0]  peak_phase_q, peak_phase_d;
   logic [11:0] peak_val_q, peak_val_d;
   logic [11:0] second_val_q, second_val_d;
   logic [4:0]  acq_sat_q, acq_sat_d;
`ifdef GPS_ACK_PEAK_SUM_EN
   logic [21:0] sum_q, sum_d;
`endif

   logic        result_event;
   logic        phase_ok;
   logic        near_peak;
   logic [12:0] peak_ext;
   logic [12:0] second_ext;
   logic [12:0] thresh;

   // Two phases are neighbours when equal or one apart, with 0 and N_PHASES-1 wrapping
   function automatic logic phase_adjacent(input logic [9:0] a, input logic [9:0] b);
      logic [10:0] ax;
      logic [10:0] bx;
      ax = {1'b0, a};
      bx = {1'b0, b};
      return (ax == bx) || (ax + 11'd1 == bx) || (bx + 11'd1 == ax) ||
             ((ax == 11'd0) && (bx == N_MAX)) || ((bx == 11'd0) && (ax == N_MAX));
   endfunction

   // Next-state and datapath: start overrides everything, events only count in COLLECT
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      prev_d       = corr_complete;
      done_d       = 1'b0;
      detected_d   = detected_q;
      peak_phase_d = peak_phase_q;
      peak_val_d   = peak_val_q;
      second_val_d = second_val_q;
      acq_sat_d    = acq_sat_q;
`ifdef GPS_ACK_PEAK_SUM_EN
      sum_d        = sum_q;
`endif
      result_event = corr_complete & ~prev_q;
      phase_ok     = ({1'b0, code_phase} < N_CNT);
      near_peak    = phase_adjacent(peak_phase_q, code_phase);
      peak_ext     = {1'b0, peak_val_q};
      second_ext   = {1'b0, second_val_q};
      thresh       = second_ext + (second_ext >> RATIO_SHIFT);

      if (start) begin
         state_d      = S_COLLECT;
         count_d      = 11'd0;
         detected_d   = 1'b0;
         peak_phase_d = 10'd0;
         peak_val_d   = 12'd0;
         second_val_d = 12'd0;
         acq_sat_d    = sat_in;
`ifdef GPS_ACK_PEAK_SUM_EN
         sum_d        = 22'd0;
`endif
      end else begin
         case (state_q)
            S_COLLECT: begin
               if (result_event && phase_ok) begin
                  if (integrator > peak_val_q) begin
                     peak_val_d   = integrator;
                     peak_phase_d = code_phase;
                     // A displaced peak that is a neighbour of the new one is the same lobe
                     if (!near_peak) begin
                        second_val_d = peak_val_q;
                     end
                  end else if (!near_peak && (integrator > second_val_q)) begin
                     second_val_d = integrator;
                  end
`ifdef GPS_ACK_PEAK_SUM_EN
                  sum_d   = sum_q + {10'd0, integrator};
`endif
                  count_d = count_q + 11'd1;
                  if (count_d == N_CNT) begin
                     state_d = S_DECIDE;
                  end
               end
            end
            S_DECIDE: begin
               detected_d = (peak_ext > thresh) && (peak_val_q != 12'd0);
               done_d     = 1'b1;
               state_d    = S_IDLE;
            end
            S_IDLE: begin
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      busy_d = (state_d != S_IDLE);
   end

   // State and registered outputs; reset clears the whole search context
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         count_q      <= 11'd0;
         prev_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         detected_q   <= 1'b0;
         peak_phase_q <= 10'd0;
         peak_val_q   <= 12'd0;
         second_val_q <= 12'd0;
         acq_sat_q    <= 5'd0;
`ifdef GPS_ACK_PEAK_SUM_EN
         sum_q        <= 22'd0;
`endif
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         prev_q       <= prev_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         detected_q   <= detected_d;
         peak_phase_q <= peak_phase_d;
         peak_val_q   <= peak_val_d;
         second_val_q <= second_val_d;
         acq_sat_q    <= acq_sat_d;
`ifdef GPS_ACK_PEAK_SUM_EN
         sum_q        <= sum_d;
`endif
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign detected   = detected_q;
   assign peak_phase = peak_phase_q;
   assign peak_val   = peak_val_q;
   assign second_val = second_val_q;
   assign acq_sat    = acq_sat_q;
`ifdef GPS_ACK_PEAK_SUM_EN
   assign sum_val    = sum_q;
`endif

endmodule

// File: tb/tb_gps_ack_peak.sv
// tb/tb_gps_ack_peak.sv - scoreboard bench for gps_ack_peak

module tb_gps_ack_peak;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [4:0]  sat_in = 5'd0;
   logic        corr_complete = 1'b0;
   logic [9:0]  code_phase = 10'd0;
   logic [11:0] integrator = 12'd0;
   logic        busy, done, detected;
   logic [9:0]  peak_phase;
   logic [11:0] peak_val, second_val;
   logic [4:0]  acq_sat;
`ifdef GPS_ACK_PEAK_SUM_EN
   logic [21:0] sum_val;
`endif

   typedef struct {
      logic [9:0]  ph;
      logic [11:0] pk;
      logic [11:0] sc;
      logic        det;
      logic [4:0]  sat;
      logic [21:0] sum;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   gps_ack_peak #(.N_PHASES(1023), .RATIO_SHIFT(1)) dut (
      .clk(clk), .rst(rst), .start(start), .sat_in(sat_in),
      .corr_complete(corr_complete), .code_phase(code_phase), .integrator(integrator),
      .busy(busy), .done(done), .detected(detected), .peak_phase(peak_phase),
      .peak_val(peak_val), .second_val(second_val),
`ifdef GPS_ACK_PEAK_SUM_EN
      .sum_val(sum_val),
`endif
      .acq_sat(acq_sat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && done) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL unexpected_done: got done=1, expected no done");
            end else begin
               e = exp_q.pop_front();
               chk("peak_phase", 32'(peak_phase), 32'(e.ph));
               chk("peak_val", 32'(peak_val), 32'(e.pk));
               chk("second_val", 32'(second_val), 32'(e.sc));
               chk("detected", 32'(detected), 32'(e.det));
               chk("acq_sat", 32'(acq_sat), 32'(e.sat));
               chk("busy_at_done", 32'(busy), 32'd0);
`ifdef GPS_ACK_PEAK_SUM_EN
               chk("sum_val", 32'(sum_val), 32'(e.sum));
`endif
            end
         end
      end
   end

   function automatic logic [11:0] val_for(input int kind, input int ph);
      case (kind)
         0: return (ph == 500) ? 12'd200 : 12'd10;
         1: return (ph == 500) ? 12'd200 : (ph == 800) ? 12'd160 : 12'd10;
         2: return (ph == 0) ? 12'd200 : (ph == 1022) ? 12'd190 :
                   (ph == 1) ? 12'd180 : (ph == 600) ? 12'd50 : 12'd10;
         3: return (ph == 300 || ph == 900) ? 12'd200 : 12'd10;
         default: return 12'd4095;
      endcase
   endfunction

   // Called at posedge+1; leaves at posedge+1 with corr_complete low for one cycle
   task automatic send_event(input int ph, input logic [11:0] v, input int hold);
      code_phase    = 10'(ph);
      integrator    = v;
      corr_complete = 1'b1;
      repeat (hold) @(posedge clk);
      #1 corr_complete = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [4:0] s, input bit coincide);
      start  = 1'b1;
      sat_in = s;
      if (coincide) begin
         code_phase    = 10'd700;
         integrator    = 12'd4000;
         corr_complete = 1'b1;
      end
      @(posedge clk);
      #1 start = 1'b0;
      corr_complete = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 20; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
      end
      #2;
      if (exp_q.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL done_timeout: got %0d pending results, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic run_search(input int kind, input logic [4:0] s, input int hold,
                             input bit oor, input bit coincide, input exp_t e);
      exp_q.push_back(e);
      do_start(s, coincide);
      for (int ph = 0; ph < 1023; ph++) begin
         if (oor && ((ph % 100) == 50 || ph == 1022))
            send_event(1023, 12'd4000, hold);
         if (ph == 1022) chk("busy_before_last", 32'(busy), 32'd1);
         send_event(ph, val_for(kind, ph), hold);
      end
      drain();
   endtask

   function automatic exp_t mk(input int ph, input int pk, input int sc, input bit det,
                               input int sat, input int sum);
      exp_t e;
      e.ph = 10'(ph); e.pk = 12'(pk); e.sc = 12'(sc);
      e.det = det; e.sat = 5'(sat); e.sum = 22'(sum);
      return e;
   endfunction

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_detected", 32'(detected), 32'd0);
      chk("rst_peak_val", 32'(peak_val), 32'd0);
      chk("rst_second_val", 32'(second_val), 32'd0);
      chk("rst_peak_phase", 32'(peak_phase), 32'd0);
      chk("rst_acq_sat", 32'(acq_sat), 32'd0);

      // Events with no start are ignored
      send_event(5, 12'd900, 1);
      send_event(6, 12'd800, 1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_peak_val", 32'(peak_val), 32'd0);

      // Single peak
      run_search(0, 5'd3, 1, 1'b0, 1'b0, mk(500, 200, 10, 1'b1, 3, 10 * 1022 + 200));
      repeat (5) @(posedge clk);
      #1;
      chk("hold_peak_val", 32'(peak_val), 32'd200);
      chk("hold_detected", 32'(detected), 32'd1);
      chk("hold_acq_sat", 32'(acq_sat), 32'd3);
      chk("hold_busy", 32'(busy), 32'd0);

      // Strong competitor: 160 + 80 = 240 >= 200
      run_search(1, 5'd7, 1, 1'b0, 1'b0, mk(500, 200, 160, 1'b0, 7, 10 * 1021 + 360));
      // Wrap adjacency around phase 0
      run_search(2, 5'd12, 1, 1'b0, 1'b0, mk(0, 200, 50, 1'b1, 12, 10 * 1019 + 620));
      // Equal peaks: the earlier one is kept, the later becomes second
      run_search(3, 5'd18, 1, 1'b0, 1'b0, mk(300, 200, 200, 1'b0, 18, 10 * 1021 + 400));
      // Long pulses plus out-of-range phases
      run_search(0, 5'd25, 5, 1'b1, 1'b0, mk(500, 200, 10, 1'b1, 25, 10 * 1022 + 200));

      // Reset in the middle of a search, then a restart coincident with an event
      do_start(5'd9, 1'b0);
      for (int ph = 0; ph < 400; ph++) send_event(ph, 12'd3000, 1);
      #3 rst = 1'b1;
      #20 rst = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_peak_val", 32'(peak_val), 32'd0);
      chk("midrst_acq_sat", 32'(acq_sat), 32'd0);
      repeat (10) @(posedge clk);
      #1;
      run_search(0, 5'd21, 1, 1'b0, 1'b1, mk(500, 200, 10, 1'b1, 21, 10 * 1022 + 200));

`ifdef GPS_ACK_PEAK_SUM_EN
      run_search(4, 5'd30, 1, 1'b0, 1'b0, mk(0, 4095, 4095, 1'b0, 30, 4189185));
`endif

      repeat (5) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
